// File: rtl/starflux_pkg.sv
// starflux_pkg: shared coordinate width, game-state encoding and screen/lives defaults
package starflux_pkg;
  localparam int COORD_W = 8;
  localparam int SCREEN_H_DEF = 120;
  localparam int LIVES_INIT_DEF = 3;
  typedef enum logic [1:0] {ALIVE = 2'd0, INVULN = 2'd1, DEAD = 2'd2} state_t;
endpackage

// File: rtl/hitbox_compare.sv
// hitbox_compare: combinational point-in-box test with 9-bit edges so boxes never wrap
module hitbox_compare
  import starflux_pkg::*;
#(
  parameter int HIT_W = 8,
  parameter int HIT_H = 8
) (
  input  logic [COORD_W-1:0] xb,
  input  logic [COORD_W-1:0] yb,
  input  logic [COORD_W-1:0] xp,
  input  logic [COORD_W-1:0] yp,
  output logic               overlap
);
  logic [COORD_W:0] xe, ye;
  assign xe = {1'b0, xp} + (COORD_W+1)'(HIT_W - 1);
  assign ye = {1'b0, yp} + (COORD_W+1)'(HIT_H - 1);
  assign overlap = (xb >= xp) && ({1'b0, xb} <= xe) && (yb >= yp) && ({1'b0, yb} <= ye);
endmodule

// File: rtl/player_hit_tracker.sv
// player_hit_tracker: bullet-vs-player hit, lives, invulnerability window and game over
// Define GOD_MODE_EN to keep hits and invulnerability but never lose lives.
module player_hit_tracker
  import starflux_pkg::*;
#(
  parameter int HIT_W        = 8,
  parameter int HIT_H        = 8,
  parameter int SCREEN_H     = SCREEN_H_DEF,
  parameter int LIVES_INIT   = LIVES_INIT_DEF,
  parameter int INVULN_TICKS = 4
) (
  input  logic               movement_handler_clock,
  input  logic               reset,
  input  logic [COORD_W-1:0] x_val_bullet,
  input  logic [COORD_W-1:0] y_val_bullet,
  input  logic [COORD_W-1:0] x_val_player,
  input  logic [COORD_W-1:0] y_val_player,
  output logic               hit_pulse,
  output logic               bullet_clear,
  output logic [1:0]         lives,
  output logic               invuln,
  output logic               game_over
);
  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] lives_n;
  logic       hit_n, clr_n, overlap, offscreen;
  hitbox_compare #(.HIT_W(HIT_W), .HIT_H(HIT_H)) u_hitbox (
    .xb(x_val_bullet),
    .yb(y_val_bullet),
    .xp(x_val_player),
    .yp(y_val_player),
    .overlap(overlap)
  );
  assign offscreen = {24'd0, y_val_bullet} >= 32'(SCREEN_H);
  assign invuln    = state == INVULN;
  assign game_over = state == DEAD;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lives_n = lives;
    hit_n   = 1'b0;
    clr_n   = 1'b0;
    if (state == ALIVE) begin
      if (overlap) begin
        hit_n = 1'b1;
        clr_n = 1'b1;
`ifdef GOD_MODE_EN
        state_n = INVULN;
        cnt_n   = 4'(INVULN_TICKS);
`else
        lives_n = lives == 2'd0 ? 2'd0 : lives - 2'd1;
        state_n = lives <= 2'd1 ? DEAD : INVULN;
        cnt_n   = lives <= 2'd1 ? cnt : 4'(INVULN_TICKS);
`endif
      end else begin
        clr_n = offscreen;
      end
    end else if (state == INVULN) begin
      clr_n   = offscreen;
      cnt_n   = cnt - 4'd1;
      state_n = cnt == 4'd1 ? ALIVE : INVULN;
    end else begin
      lives_n = 2'd0;
    end
  end
  always_ff @(posedge movement_handler_clock) begin
    if (reset) begin
      state        <= ALIVE;
      cnt          <= 4'd0;
      lives        <= 2'(LIVES_INIT);
      hit_pulse    <= 1'b0;
      bullet_clear <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      lives        <= lives_n;
      hit_pulse    <= hit_n;
      bullet_clear <= clr_n;
    end
  end
endmodule

// File: tb/tb_player_hit_tracker.sv
// tb_player_hit_tracker: directed checks of hit, invulnerability, off-screen, game over and no-wrap
module tb_player_hit_tracker;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] xb = 8'd0, yb = 8'd0, xp = 8'd40, yp = 8'd100;
  logic       hit_pulse, bullet_clear, invuln, game_over;
  logic [1:0] lives;
  logic [5:0] obs;
  int errors = 0;
  int checks = 0;

  player_hit_tracker dut (
    .movement_handler_clock(clk),
    .reset(reset),
    .x_val_bullet(xb),
    .y_val_bullet(yb),
    .x_val_player(xp),
    .y_val_player(yp),
    .hit_pulse(hit_pulse),
    .bullet_clear(bullet_clear),
    .lives(lives),
    .invuln(invuln),
    .game_over(game_over)
  );

  always #5 clk = ~clk;
  // observed word: {hit_pulse, bullet_clear, lives[1:0], invuln, game_over}
  assign obs = {hit_pulse, bullet_clear, lives, invuln, game_over};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    xp = 8'd40; yp = 8'd100; xb = 8'd0; yb = 8'd0;
    reset = 1'b1;
    step();
    step();
    checks++;
    if (obs !== 6'b001100) begin errors++; $display("FAIL reset_state got=%b exp=%b", obs, 6'b001100); end
    reset = 1'b0;
  endtask

  task automatic test_hit_invuln();
    xp = 8'd40; yp = 8'd100; xb = 8'd44; yb = 8'd104;
    step();
    checks++;
    if (obs !== 6'b111010) begin errors++; $display("FAIL first_hit got=%b exp=%b", obs, 6'b111010); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== 6'b001010) begin errors++; $display("FAIL invuln_hold%0d got=%b exp=%b", i, obs, 6'b001010); end
    end
    step();
    checks++;
    if (obs !== 6'b001000) begin errors++; $display("FAIL invuln_end got=%b exp=%b", obs, 6'b001000); end
    step();
    checks++;
    if (obs !== 6'b110110) begin errors++; $display("FAIL second_hit got=%b exp=%b", obs, 6'b110110); end
    xb = 8'd0; yb = 8'd0;
    repeat (4) step();
    checks++;
    if (obs !== 6'b000100) begin errors++; $display("FAIL after_second got=%b exp=%b", obs, 6'b000100); end
  endtask

  task automatic test_offscreen();
    do_reset();
    xp = 8'd40; yp = 8'd100; xb = 8'd10; yb = 8'd120;
    step();
    checks++;
    if (obs !== 6'b011100) begin errors++; $display("FAIL offscreen got=%b exp=%b", obs, 6'b011100); end
    yb = 8'd119;
    step();
    checks++;
    if (obs !== 6'b001100) begin errors++; $display("FAIL last_row got=%b exp=%b", obs, 6'b001100); end
    xp = 8'd40; yp = 8'd116; xb = 8'd44; yb = 8'd120;
    step();
    checks++;
    if (obs !== 6'b111010) begin errors++; $display("FAIL hit_and_off got=%b exp=%b", obs, 6'b111010); end
    xb = 8'd10; yb = 8'd200;
    step();
    checks++;
    if (obs !== 6'b011010) begin errors++; $display("FAIL invuln_off got=%b exp=%b", obs, 6'b011010); end
    yb = 8'd50;
    step();
    checks++;
    if (obs !== 6'b001010) begin errors++; $display("FAIL clear_drop got=%b exp=%b", obs, 6'b001010); end
  endtask

  task automatic test_game_over();
    logic [5:0] exp;
    do_reset();
    xp = 8'd40; yp = 8'd100;
    for (int n = 0; n < 3; n++) begin
      xb = 8'd44; yb = 8'd104;
      step();
      exp = (n == 2) ? 6'b110001 : {2'b11, 2'(2 - n), 2'b10};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL hit%0d got=%b exp=%b", n, obs, exp); end
      xb = 8'd0; yb = 8'd0;
      repeat (4) step();
    end
    xb = 8'd44; yb = 8'd104;
    step();
    checks++;
    if (obs !== 6'b000001) begin errors++; $display("FAIL dead_overlap got=%b exp=%b", obs, 6'b000001); end
    yb = 8'd130;
    step();
    checks++;
    if (obs !== 6'b000001) begin errors++; $display("FAIL dead_off got=%b exp=%b", obs, 6'b000001); end
    reset = 1'b1;
    step();
    checks++;
    if (obs !== 6'b001100) begin errors++; $display("FAIL dead_reset got=%b exp=%b", obs, 6'b001100); end
    reset = 1'b0;
  endtask

  task automatic test_no_wrap();
    do_reset();
    xp = 8'd250; yp = 8'd100; xb = 8'd2; yb = 8'd104;
    step();
    checks++;
    if (obs !== 6'b001100) begin errors++; $display("FAIL wrap_x2 got=%b exp=%b", obs, 6'b001100); end
    xb = 8'd249;
    step();
    checks++;
    if (obs !== 6'b001100) begin errors++; $display("FAIL left_edge got=%b exp=%b", obs, 6'b001100); end
    xb = 8'd255;
    step();
    checks++;
    if (obs !== 6'b111010) begin errors++; $display("FAIL x255_hit got=%b exp=%b", obs, 6'b111010); end
    do_reset();
    xp = 8'd40; yp = 8'd100; xb = 8'd47; yb = 8'd108;
    step();
    checks++;
    if (obs !== 6'b001100) begin errors++; $display("FAIL below_box got=%b exp=%b", obs, 6'b001100); end
    xb = 8'd48; yb = 8'd104;
    step();
    checks++;
    if (obs !== 6'b001100) begin errors++; $display("FAIL right_box got=%b exp=%b", obs, 6'b001100); end
    xb = 8'd47; yb = 8'd107;
    step();
    checks++;
    if (obs !== 6'b111010) begin errors++; $display("FAIL corner_hit got=%b exp=%b", obs, 6'b111010); end
  endtask

  task automatic test_god_mode();
    do_reset();
    xp = 8'd40; yp = 8'd100;
    for (int n = 0; n < 4; n++) begin
      xb = 8'd44; yb = 8'd104;
      step();
      checks++;
      if (obs !== 6'b111110) begin errors++; $display("FAIL god_hit%0d got=%b exp=%b", n, obs, 6'b111110); end
      xb = 8'd0; yb = 8'd0;
      repeat (4) step();
      checks++;
      if (obs !== 6'b001100) begin errors++; $display("FAIL god_idle%0d got=%b exp=%b", n, obs, 6'b001100); end
    end
  endtask

  initial begin
    test_reset();
`ifdef GOD_MODE_EN
    test_god_mode();
`else
    test_hit_invuln();
    test_offscreen();
    test_game_over();
    test_no_wrap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
